// File: rtl/microop_sequencer.sv
// ============================================================================
// Module   : microop_sequencer
// Purpose  : Microcode sequencer. Holds the opcode and micro-op counter, and
//            decodes microcode words into datapath strobes. Optional
//            SINGLE_STEP_EN adds a STEP input that halts at instruction
//            boundaries.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module microop_sequencer #(
  parameter logic [5:0] RESET_OPCODE = 6'd0,
  parameter logic [5:0] FETCH_OPCODE = 6'd1,
  parameter logic [4:0] PC_REG       = 5'd31
) (
  input  logic        CLK,
  input  logic        N_RST,
`ifdef SINGLE_STEP_EN
  input  logic        STEP,
`endif
  output logic [10:0] MC_ADDR,
  input  logic [31:0] MC_DATA,
  input  logic [31:0] OPWORD,
  input  logic [31:0] BUS,
  input  logic        MMU_READY,
  output logic [4:0]  REG_IDX,
  output logic [31:0] CTRL_CONST,
  output logic [9:0]  OUT_EN,
  output logic [6:0]  IN_WE,
  output logic [2:0]  MLU_OP,
  output logic        MLU_CARRY,
  output logic [1:0]  SHIFTER_OP,
  output logic        ISSUE,
  output logic        FAULT
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FAULT     = 2'd1,
    ST_STEP_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [4:0] count_q, count_d;
  logic       issue_q, issue_d;

  // Microcode word fields
  logic [5:0] ctrl_data;
  logic [1:0] reg_sel;
  logic [3:0] out_plane;
  logic [2:0] in_plane;
  logic       cnt_rst;
  logic       opcode_sel;
  logic       stall;
  logic       bad_word;
  logic [9:0] out_dec;
  logic [6:0] in_dec;
  logic       unused_bits;

  assign ctrl_data  = MC_DATA[5:0];
  assign reg_sel    = MC_DATA[7:6];
  assign out_plane  = MC_DATA[11:8];
  assign in_plane   = MC_DATA[14:12];
  assign cnt_rst    = MC_DATA[15];
  assign opcode_sel = MC_DATA[22];

  assign MC_ADDR    = {opcode_q, count_q};
  assign CTRL_CONST = {26'd0, ctrl_data};
  assign MLU_OP     = MC_DATA[18:16];
  assign MLU_CARRY  = MC_DATA[19];
  assign SHIFTER_OP = MC_DATA[21:20];
  assign ISSUE      = issue_q;
  assign FAULT      = (state_q == ST_FAULT);

  // Code 0 selects no driver; codes past the vector width shift out to zero.
  assign out_dec = (10'd1 << out_plane) & 10'h3FE;
  assign in_dec  = (7'd1 << in_plane) & 7'h7E;

  assign stall    = ((out_plane == 4'd4) || (in_plane == 3'd4)) && !MMU_READY;
  assign bad_word = (out_plane >= 4'd10) || (in_plane == 3'd7) ||
                    (MC_DATA[31:23] != 9'd0) ||
                    ((count_q == 5'd31) && !cnt_rst);

  assign unused_bits = ^{OPWORD[10:0], BUS[31:6], FETCH_OPCODE};

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    count_d  = count_q;
    issue_d  = 1'b0;
    OUT_EN   = 10'd0;
    IN_WE    = 7'd0;

    case (reg_sel)
      2'd0:    REG_IDX = OPWORD[25:21];
      2'd1:    REG_IDX = OPWORD[20:16];
      2'd2:    REG_IDX = OPWORD[15:11];
      default: REG_IDX = ctrl_data[4:0];
    endcase

    case (state_q)
      ST_RUN: begin
        OUT_EN = out_dec;
        if (!stall) begin
          IN_WE = in_dec;
          if (bad_word) begin
            state_d = ST_FAULT;
          end else begin
            count_d = cnt_rst ? 5'd0 : count_q + 5'd1;
            if (in_plane == 3'd6) begin
              opcode_d = opcode_sel ? BUS[5:0] : OPWORD[31:26];
              issue_d  = !opcode_sel;
`ifdef SINGLE_STEP_EN
              if (opcode_d == FETCH_OPCODE) state_d = ST_STEP_WAIT;
`endif
            end
          end
        end
      end
`ifdef SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (STEP) state_d = ST_RUN;
      end
`endif
      ST_FAULT: begin
        REG_IDX = PC_REG;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // No strobe may leave the block while reset is asserted.
    if (!N_RST) begin
      OUT_EN = 10'd0;
      IN_WE  = 7'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q  <= ST_RUN;
      opcode_q <= RESET_OPCODE;
      count_q  <= 5'd0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
      issue_q  <= issue_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/microop_sequencer.md
Name: microop_sequencer

Overview:
- Control-logic sequencer that reads the microcode store.
- Owns the 6-bit opcode register and the 5-bit micro-op counter, and drives the microcode address from them.
- Decodes the 32-bit microcode word into one-hot bus output enables, one-hot write strobes, register index and ALU/shifter controls.
- Sits between the microcode store and the datapath (register file, TMP0/TMP1, MMU, MLU, shifter, opword register).

Parameters:
- RESET_OPCODE, 0, opcode loaded on reset.
- FETCH_OPCODE, 1, opcode single-step treats as an instruction boundary.
- PC_REG, 31, register index reported on REG_IDX while in FAULT.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- N_RST  in  1  synchronous active-low reset.
- MC_ADDR  out  11  microcode address {opcode[5:0], count[4:0]}.
- MC_DATA  in  32  microcode word. [5:0] ctrl_data, [7:6] reg_sel, [11:8] out_plane, [14:12] in_plane, [15] counter reset, [18:16] mlu_op, [19] mlu_carry, [21:20] shifter, [22] opcode_sel, [31:23] must be 0.
- OPWORD  in  32  current opword register contents.
- BUS  in  32  data bus; [5:0] is the opcode source when opcode_sel=1.
- MMU_READY  in  1  MMU completion handshake.
- REG_IDX  out  5  register file index.
- CTRL_CONST  out  32  ctrl_data zero-extended, for OUT_CTRL_DATA.
- OUT_EN  out  10  one-hot bus driver enable; bit n = out_plane code n; bit0 unused.
- IN_WE  out  7  one-hot write strobe; bit n = in_plane code n; bit0 unused.
- MLU_OP  out  3  pass-through of MC_DATA[18:16].
- MLU_CARRY  out  1  pass-through of MC_DATA[19].
- SHIFTER_OP  out  2  pass-through of MC_DATA[21:20].
- ISSUE  out  1  one-cycle pulse when an opcode is loaded from OPWORD.
- FAULT  out  1  sticky fault indicator.

Behaviour:
- State register values: RUN, FAULT, plus STEP_WAIT with the option. Reset: opcode=RESET_OPCODE, count=0, state=RUN, FAULT=0, ISSUE=0.
- Strobe gating during reset: while N_RST=0, OUT_EN and IN_WE are 0.
- In the first cycle after reset, MC_ADDR=0.
- MC_DATA is combinational from MC_ADDR; decode is combinational from MC_DATA and state.
- REG_IDX by reg_sel: 0 selects OPWORD[25:21], 1 selects OPWORD[20:16], 2 selects OPWORD[15:11], 3 selects ctrl_data[4:0].
- Stall: condition is (out_plane==4 or in_plane==4) and MMU_READY=0.
  - OUT_EN remains asserted.
  - IN_WE is all 0.
  - Counter and opcode are held.
  - The step completes in the first cycle MMU_READY=1.
- Commit (RUN, not stalled):
  - IN_WE[in_plane] is asserted for that cycle.
  - If in_plane==6: opcode becomes OPWORD[31:26] when opcode_sel=0, or BUS[5:0] when opcode_sel=1.
  - ISSUE=1 in the following cycle iff the opcode came from OPWORD.
  - Counter: if misc bit set, count becomes 0; otherwise count becomes count+1.
- Simultaneous events: an opcode load together with a counter reset gives the new opcode at count 0. A counter reset alone gives the same opcode at count 0.
- FAULT entry (checked only on a commit cycle):
  - out_plane >= 10;
  - in_plane == 7;
  - MC_DATA[31:23] != 0;
  - count==31 without counter reset (no wrap).
- In FAULT:
  - FAULT=1, OUT_EN=0, IN_WE=0, MC_ADDR is frozen, REG_IDX=PC_REG.
  - Exit is only via reset.
- Reset priority: reset mid-stall or mid-instruction wins immediately; no strobe is emitted in the reset cycle.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Extra input STEP (1 bit).
- When defined:
  - A commit that loads opcode==FETCH_OPCODE moves the state to STEP_WAIT.
  - In STEP_WAIT: OUT_EN=0, IN_WE=0, counter held.
  - A one-cycle STEP pulse returns the state to RUN at the next edge.
  - STEP while in RUN is ignored.
- When undefined:
  - No STEP port; STEP_WAIT is unreachable.
  - Behaviour is identical to always-RUN.

Test Plan:
- Reset release, MC_DATA=0x000030DF (ctrl=31, reg_sel=3, in=3?):
  - MC_ADDR=0x000, REG_IDX=31.
  - Next edge gives MC_ADDR=0x001.
  - IN_WE is one-hot on the encoded plane only.
- Fetch sequence (opcode 1), OPWORD=0x0C22_0010:
  - Step 4 with in=6, misc=1, opcode_sel=0 gives MC_ADDR=0x060 next cycle (opcode 3, count 0).
  - ISSUE pulses once.
- MMU step (out=4, in=5), MMU_READY low for 3 cycles:
  - OUT_EN[4]=1 for 4 cycles.
  - IN_WE[5] only in cycle 4.
  - Count advances once.
- Count reaches 31 with misc=0:
  - FAULT=1 next cycle; all strobes 0; MC_ADDR frozen.
  - N_RST low for one edge clears FAULT and gives MC_ADDR=0.
- Word with in=6, opcode_sel=1, misc=1, BUS[5:0]=0x04:
  - MC_ADDR=0x080; ISSUE=0.
- SINGLE_STEP_EN:
  - After loading opcode 1, strobes stay 0 for 5 cycles.
  - A STEP pulse resumes with MC_ADDR=0x020.
